// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator button-pattern decoder.
// The op codes are named after the button pattern that each one regenerates.
package calc_pkg;

    typedef logic [3:0] op_t;
    typedef logic [2:0] btn_pat_t;   // {btnl, btnc, btnr}

    localparam op_t OP_NONE = 4'b0000;
    localparam op_t OP_R    = 4'b0001;
    localparam op_t OP_C    = 4'b0010;
    localparam op_t OP_CR   = 4'b0110;
    localparam op_t OP_L    = 4'b0100;
    localparam op_t OP_LR   = 4'b1001;
    localparam op_t OP_LC   = 4'b1010;
    localparam op_t OP_LCR  = 4'b0101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [7:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/calc_dec_if.sv
// Operation handshake between the op source and the decoder.
interface calc_dec_if;
    import calc_pkg::*;

    logic op_valid;
    op_t  op;
    logic op_ready;

    modport master (output op_valid, output op, input op_ready);
    modport slave  (input op_valid, input op, output op_ready);

endinterface

// File: rtl/calc_dec_lut.sv
// Combinational op-code to button-pattern lookup.
// Every code that is not listed decodes as illegal, with an all-zero pattern.
module calc_dec_lut
    import calc_pkg::*;
(
    input  op_t      op,
    output logic     legal,
    output btn_pat_t pat
);

    always_comb begin
        legal = 1'b1;
        pat   = 3'b000;
        case (op)
            OP_NONE: pat = 3'b000;
            OP_R:    pat = 3'b001;
            OP_C:    pat = 3'b010;
            OP_CR:   pat = 3'b011;
            OP_L:    pat = 3'b100;
            OP_LR:   pat = 3'b101;
            OP_LC:   pat = 3'b110;
            OP_LCR:  pat = 3'b111;
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/calc_dec.sv
// Regenerates a timed button pulse from an ALU op code, followed by an idle gap.
// Illegal codes are dropped and counted in a sticky error flag and a saturating counter.
//
// state | meaning
// IDLE  | op_ready high, waiting for an op
// HOLD  | driving the latched pattern for PULSE_CYCLES cycles
// GAP   | buttons low for GAP_CYCLES cycles before the next op
module calc_dec
    import calc_pkg::*;
#(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 2
)
(
    input  logic            clk,
    input  logic            rst,
    calc_dec_if.slave       bus,
    input  logic            err_clr,
    output logic            btnl,
    output logic            btnc,
    output logic            btnr,
    output logic            busy,
    output logic            err,
    output logic [7:0]      err_cnt
);

    // Down-counter reload values: the phase ends when the counter reaches zero.
    localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);
    localparam logic [7:0] GAP_LAST   = 8'(GAP_CYCLES - 1);

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    btn_pat_t   btn_q, btn_nxt;
    logic       busy_nxt;
    logic       err_nxt;
    logic [7:0] err_cnt_nxt;

    logic       lut_legal;
    btn_pat_t   lut_pat;
    logic       accept;
    logic       bad_accept;

    calc_dec_lut u_lut (
        .op    (bus.op),
        .legal (lut_legal),
        .pat   (lut_pat)
    );

    assign bus.op_ready = (state == ST_IDLE);
    assign accept       = bus.op_valid && bus.op_ready;
    assign bad_accept   = accept && !lut_legal;

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        btn_nxt     = 3'b000;
        err_nxt     = err;
        err_cnt_nxt = err_cnt;

        unique case (state)
            ST_IDLE: begin
                if (accept && lut_legal) begin
                    state_nxt = ST_HOLD;
                    cnt_nxt   = PULSE_LAST;
                    btn_nxt   = lut_pat;
                end
            end
            ST_HOLD: begin
                if (cnt == 8'd0) begin
                    if (GAP_CYCLES == 0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_GAP;
                        cnt_nxt   = GAP_LAST;
                    end
                end else begin
                    cnt_nxt = cnt - 8'd1;
                    btn_nxt = btn_q;
                end
            end
            ST_GAP: begin
                if (cnt == 8'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 8'd1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // A clear in the same cycle as an illegal code leaves exactly that one counted.
        if (err_clr) begin
            err_nxt     = bad_accept;
            err_cnt_nxt = {7'd0, bad_accept};
        end else if (bad_accept) begin
            err_nxt = 1'b1;
            if (err_cnt != ERR_CNT_MAX) begin
                err_cnt_nxt = err_cnt + 8'd1;
            end
        end

        busy_nxt = (state_nxt != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= 8'd0;
            btn_q   <= 3'b000;
            busy    <= 1'b0;
            err     <= 1'b0;
            err_cnt <= 8'd0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            btn_q   <= btn_nxt;
            busy    <= busy_nxt;
            err     <= err_nxt;
            err_cnt <= err_cnt_nxt;
        end
    end

    assign {btnl, btnc, btnr} = btn_q;

endmodule
